dcache_ram_bridge: RTL and testbench
====================================

DCACHE_RAM_BRIDGE -- requirements
Module: dcache_ram_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width; a line is 4 words.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rd_req_i, input, 1, cache refill request (level).
REQ-006 SHALL have port rd_addr_i, input, ADDR_W, refill byte address.
REQ-007 SHALL have port rd_rdy_o, output, 1, refill word valid this cycle.
REQ-008 SHALL have port rd_data_o, output, DATA_W, refill word.
REQ-009 SHALL have port rd_num_o, output, 3, words delivered including the current one (1..4); 0 when not delivering.
REQ-010 SHALL have port rd_bank_o, output, 2, line word index of rd_data_o.
REQ-011 SHALL have port wr_req_i, input, 1, write-back request.
REQ-012 SHALL have port wr_addr_i, input, ADDR_W, write-back line address.
REQ-013 SHALL have port wr_data_i, input, 4*DATA_W, write-back line; word k in bits [32k+31:32k].
REQ-014 SHALL have port wr_rdy_o, output, 1, write-back buffer free (level).
REQ-015 SHALL have memory ports: mem_req_o (out, 1), mem_we_o (out, 1), mem_addr_o (out, ADDR_W), mem_wdata_o (out, DATA_W), mem_gnt_i (in, 1, request accepted), mem_rvalid_i (in, 1, read data valid), and mem_rdata_i (in, DATA_W).

Function
REQ-016 SHALL implement states IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE, plus a 2-bit beat counter.
REQ-017 SHALL accept a write-back in any state when wr_rdy_o=1 and wr_req_i=1: latch address[ADDR_W-1:4] and 128-bit data, and drive wr_rdy_o=0 from the next cycle.
REQ-018 SHALL, in IDLE with the buffer full, enter WR_REQ; the buffer SHALL have priority over rd_req_i.
REQ-019 SHALL, in WR_REQ, drive mem_req_o=1, mem_we_o=1, mem_addr_o={line,beat,2'b00}, mem_wdata_o=word[beat]; each mem_gnt_i advances beat.
REQ-020 SHALL, on the 4th grant, free the buffer (wr_rdy_o=1 next cycle) and return to IDLE.
REQ-021 SHALL, in IDLE with no buffered write and rd_req_i=1, latch rd_addr_i, set beat to the start word, and enter RD_REQ.
REQ-022 SHALL, in RD_REQ, drive mem_req_o=1, mem_we_o=0, mem_addr_o={line,beat,2'b00}; on mem_gnt_i it SHALL enter RD_WAIT, so only one access is outstanding.
REQ-023 SHALL, in RD_WAIT, on mem_rvalid_i drive rd_rdy_o=1, rd_data_o=mem_rdata_i, rd_bank_o=beat, and rd_num_o=count in the same cycle (combinational pass-through), then increment beat modulo 4.
REQ-024 SHALL return to RD_REQ after beats 1..3 and enter DONE after beat 4.
REQ-025 SHALL spend exactly one cycle in DONE ignoring rd_req_i, then return to IDLE; the cache SHALL drop rd_req_i on the rd_num_o=4 cycle.
REQ-026 SHALL ignore mem_rvalid_i outside RD_WAIT.
REQ-027 SHALL ignore rd_req_i and address changes outside IDLE.
REQ-028 SHALL process a simultaneous wr_req_i and rd_req_i in IDLE write first; the refill starts on the cycle after the 4th write grant.
REQ-029 SHALL keep mem_addr_o, mem_we_o and mem_wdata_o stable while mem_req_o=1 and mem_gnt_i=0.
REQ-030 SHALL drive rd_rdy_o=0, rd_num_o=0, rd_bank_o=0 and rd_data_o=0 whenever no word is delivered.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, go to IDLE, set beat=0, invalidate the buffer, and set mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rd_rdy_o=0, rd_num_o=0, rd_bank_o=0, rd_data_o=0 and wr_rdy_o=1.
REQ-032 SHALL, on reset mid-operation, discard any partial refill or write-back; no further beats are delivered and no write is resumed.

Configuration
REQ-033 SHALL, with macro DCACHE_CRITICAL_WORD_FIRST_EN defined, start the refill at word rd_addr_i[3:2] and wrap modulo 4 (e.g. 2,3,0,1).
REQ-034 SHALL, without DCACHE_CRITICAL_WORD_FIRST_EN, always fetch words 0,1,2,3; write-back order is always 0..3.

Verification
REQ-035 SHALL cover a plain refill: rd_addr_i=0x0000_1008, memory returns 0xA0..0xA3 with 1-cycle grant and 2-cycle rvalid -> addresses 0x1000,0x1004,0x1008,0x100C; rd_num_o 1,2,3,4; rd_bank_o 0..3 (0x1008,0x100C,0x1000,0x1004 and banks 2,3,0,1 with the macro defined).
REQ-036 SHALL cover a write-back: wr_addr_i=0x0000_2000, wr_data_i=0x44444444_33333333_22222222_11111111 -> four writes 0x2000..0x200C with data 0x11111111..0x44444444; wr_rdy_o=0 until the cycle after the 4th grant.
REQ-037 SHALL cover simultaneous wr_req_i (0x3000) and rd_req_i (0x4000) in IDLE -> all four 0x3000 writes are granted before the first 0x4000 read request.
REQ-038 SHALL cover a stalled grant: mem_gnt_i=0 for 5 cycles during RD_REQ -> mem_addr_o and mem_req_o are held constant, and no rd_rdy_o occurs.
REQ-039 SHALL cover reset mid-refill: rst=1 after beat 2 -> all outputs reach reset values next cycle, a stray mem_rvalid_i then gives no rd_rdy_o, and wr_rdy_o=1.
REQ-040 SHALL cover a spurious mem_rvalid_i in IDLE -> rd_rdy_o stays 0 and the state is unchanged.

Source files
------------

// File: rtl/dcache_ram_bridge.sv
// dcache_ram_bridge
// Bridges a data cache (4-word line refills and line write-backs) onto a
// single-word request/grant memory port with only one read outstanding.
// A one-entry write-back buffer accepts a dirty line at any time while free.
// Buffered write-backs go to memory ahead of refills.
// Optional build macro:
//   DCACHE_CRITICAL_WORD_FIRST_EN - a refill starts at the requested word
//   and wraps modulo 4. Without it, a refill always fetches words 0..3.
module dcache_ram_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // refill side
    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic                  rd_rdy_o,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic [2:0]            rd_num_o,
    output logic [1:0]            rd_bank_o,
    // write-back side
    input  logic                  wr_req_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [4*DATA_W-1:0]   wr_data_i,
    output logic                  wr_rdy_o,
    // memory side
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]          state_r;
    logic [1:0]          beat_r;      // line word index of the current access
    logic [1:0]          cnt_r;       // refill words already delivered
    logic [ADDR_W-5:0]   rd_line_r;
    logic                buf_valid_r;
    logic [ADDR_W-5:0]   wr_line_r;
    logic [4*DATA_W-1:0] wr_data_r;

    logic                wr_accept_s;
    logic                rd_beat_s;
    logic                last_wr_grant_s;
    logic [1:0]          start_beat_s;
    logic [DATA_W-1:0]   wr_word_s;
    logic                unused_addr_bits_s;

    assign wr_rdy_o        = ~buf_valid_r;
    assign wr_accept_s     = ~buf_valid_r & wr_req_i;
    assign rd_beat_s       = (state_r == ST_RD_WAIT) & mem_rvalid_i;
    assign last_wr_grant_s = (state_r == ST_WR_REQ) & mem_gnt_i & (beat_r == 2'd3);

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    assign start_beat_s = rd_addr_i[3:2];
`else
    assign start_beat_s = 2'b00;
`endif

    // Low address bits never reach the memory address; only the word index matters.
    assign unused_addr_bits_s = ^{rd_addr_i[3:0], wr_addr_i[3:0]};

    // Write-back buffer: capture a line while free, release it on the last write grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_r <= 1'b0;
            wr_line_r   <= '0;
            wr_data_r   <= '0;
        end else if (wr_accept_s) begin
            buf_valid_r <= 1'b1;
            wr_line_r   <= wr_addr_i[ADDR_W-1:4];
            wr_data_r   <= wr_data_i;
        end else if (last_wr_grant_s) begin
            buf_valid_r <= 1'b0;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end

    // Main sequencer: write-back first, then single-outstanding refill beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            beat_r    <= 2'd0;
            cnt_r     <= 2'd0;
            rd_line_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A write accepted this cycle also beats a same-cycle refill request.
                    if (buf_valid_r || wr_accept_s) begin
                        state_r <= ST_WR_REQ;
                        beat_r  <= 2'd0;
                    end else if (rd_req_i) begin
                        state_r   <= ST_RD_REQ;
                        rd_line_r <= rd_addr_i[ADDR_W-1:4];
                        beat_r    <= start_beat_s;
                        cnt_r     <= 2'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (mem_gnt_i) begin
                        beat_r <= beat_r + 2'd1;
                        if (beat_r == 2'd3) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_WR_REQ;
                        end
                    end else begin
                        state_r <= ST_WR_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (mem_gnt_i) begin
                        state_r <= ST_RD_WAIT;
                    end else begin
                        state_r <= ST_RD_REQ;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        beat_r <= beat_r + 2'd1;
                        cnt_r  <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_RD_REQ;
                        end
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_DONE: begin
                    // One dead cycle lets the cache drop rd_req_i before IDLE samples it.
                    state_r <= ST_IDLE;
                    cnt_r   <= 2'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    beat_r  <= 2'd0;
                    cnt_r   <= 2'd0;
                end
            endcase
        end
    end

    // Select the buffered write-back word for the current beat.
    always_comb begin
        wr_word_s = wr_data_r[DATA_W-1:0];
        case (beat_r)
            2'd0:    wr_word_s = wr_data_r[DATA_W-1:0];
            2'd1:    wr_word_s = wr_data_r[2*DATA_W-1:DATA_W];
            2'd2:    wr_word_s = wr_data_r[3*DATA_W-1:2*DATA_W];
            2'd3:    wr_word_s = wr_data_r[4*DATA_W-1:3*DATA_W];
            default: wr_word_s = wr_data_r[DATA_W-1:0];
        endcase
    end

    // Memory request decode; depends only on registers so it holds steady under a stall.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_r)
            ST_WR_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {wr_line_r, beat_r, 2'b00};
                mem_wdata_o = wr_word_s;
            end
            ST_RD_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b0;
                mem_addr_o  = {rd_line_r, beat_r, 2'b00};
                mem_wdata_o = '0;
            end
            default: begin
                mem_req_o   = 1'b0;
                mem_we_o    = 1'b0;
                mem_addr_o  = '0;
                mem_wdata_o = '0;
            end
        endcase
    end

    // Refill word pass-through: read data reaches the cache in the rvalid cycle.
    always_comb begin
        rd_rdy_o  = 1'b0;
        rd_data_o = '0;
        rd_num_o  = 3'd0;
        rd_bank_o = 2'd0;
        if (rd_beat_s) begin
            rd_rdy_o  = 1'b1;
            rd_data_o = mem_rdata_i;
            rd_num_o  = {1'b0, cnt_r} + 3'd1;
            rd_bank_o = beat_r;
        end else begin
            rd_rdy_o  = 1'b0;
            rd_data_o = '0;
            rd_num_o  = 3'd0;
            rd_bank_o = 2'd0;
        end
    end

endmodule

// File: tb/tb_dcache_ram_bridge.sv
// Testbench for dcache_ram_bridge: memory model with configurable grant stalls
// and fixed two-cycle read latency, plus queue-based expectations for memory
// accesses and refill words.
module tb_dcache_ram_bridge;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req_i = 1'b0;
    logic [31:0]  rd_addr_i = 32'h0;
    logic         rd_rdy_o;
    logic [31:0]  rd_data_o;
    logic [2:0]   rd_num_o;
    logic [1:0]   rd_bank_o;
    logic         wr_req_i = 1'b0;
    logic [31:0]  wr_addr_i = 32'h0;
    logic [127:0] wr_data_i = 128'h0;
    logic         wr_rdy_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_gnt_i = 1'b0;
    logic         mem_rvalid_i = 1'b0;
    logic [31:0]  mem_rdata_i = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    logic [64:0] exp_mem[$];   // {we, addr, wdata (0 for reads)}
    logic [36:0] exp_rd[$];    // {data, num, bank}

    // memory model state (owned by the model process)
    int          stall_seen = 0;
    int          stall_left = 0;
    int          stray_seen = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    bit          pend_gen = 1'b0;
    bit          rv_gen = 1'b0;
    // monitor state (owned by the model process)
    int          cyc = 0;
    int          n_deliv = 0;
    int          wgrants = 0;
    int          last_wg_cyc = 0;
    int          n_stall = 0;
    bit          prev_stall = 1'b0;
    logic [65:0] held = 66'h0;
    // driver-owned knobs
    int          stall_id = 0;
    int          stall_cfg = 0;
    int          stray_id = 0;

    dcache_ram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_rdy_o(rd_rdy_o),
        .rd_data_o(rd_data_o), .rd_num_o(rd_num_o), .rd_bank_o(rd_bank_o),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_rdy_o(wr_rdy_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000100) return 32'h000000A0 + {30'h0, a[3:2]};
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic push_refill(input logic [31:0] addr);
        logic [1:0]  s;
        logic [1:0]  b;
        logic [31:0] a;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
        s = addr[3:2];
`else
        s = 2'd0;
`endif
        for (int k = 0; k < 4; k++) begin
            b = s + 2'(k);
            a = {addr[31:4], b, 2'b00};
            exp_mem.push_back({1'b0, a, 32'h0});
            exp_rd.push_back({mem_word(a), 3'(k + 1), b});
        end
    endtask

    task automatic push_write(input logic [31:0] addr, input logic [127:0] data);
        for (int k = 0; k < 4; k++)
            exp_mem.push_back({1'b1, addr[31:4], 2'(k), 2'b00, data[32*k +: 32]});
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_refill(input bit scramble);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (scramble && i == 0) rd_addr_i = 32'hDEAD_BEEC;
            if (rd_num_o == 3'd4) begin
                rd_req_i = 1'b0;
                done = 1'b1;
                break;
            end
        end
        check("refill_done", done, 1);
        for (int i = 0; i < 20 && (exp_mem.size() != 0 || exp_rd.size() != 0); i++) tick();
        check("drain", exp_mem.size() + exp_rd.size(), 0);
        tick();
        tick();
    endtask

    // Memory model and output monitor, evaluated once per cycle on the falling edge.
    always @(negedge clk) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hBAD0_BAD0;
        rv_gen       = 1'b0;
        if (stall_id != stall_seen) begin
            stall_left = stall_cfg;
            stall_seen = stall_id;
        end
        if (stray_id != stray_seen) begin
            stray_seen   = stray_id;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'h5757_5757;
        end else if (pend) begin
            if (pend_cnt == 1) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(pend_addr);
                rv_gen       = pend_gen;
                pend         = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (mem_req_o && !rst) begin
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                mem_gnt_i = 1'b1;
                if (!mem_we_o) begin
                    pend      = 1'b1;
                    pend_cnt  = 2;
                    pend_addr = mem_addr_o;
                    pend_gen  = 1'b1;
                end
            end
        end
        #1;
        cyc++;
        if (rst) begin
            exp_mem.delete();
            exp_rd.delete();
            pend_gen   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("rd_rdy", rd_rdy_o, rv_gen);
            if (rd_rdy_o) begin
                n_deliv++;
                if (exp_rd.size() == 0) check("rd_extra", 1, 0);
                else check("rd_beat", {rd_data_o, rd_num_o, rd_bank_o}, exp_rd.pop_front());
            end else begin
                check("rd_quiet", {rd_data_o, rd_num_o, rd_bank_o}, 0);
            end
            if (prev_stall)
                check("hold", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, held);
            if (mem_req_o && mem_gnt_i) begin
                if (exp_mem.size() == 0) check("mem_extra", 1, 0);
                else check("mem_acc", {mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 32'h0},
                           exp_mem.pop_front());
                if (mem_we_o) begin
                    wgrants++;
                    last_wg_cyc = cyc;
                end
            end
            prev_stall = mem_req_o && !mem_gnt_i;
            if (prev_stall) n_stall++;
            held = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dv;
        bit seen;
        tick();
        tick();
        check("rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 0);
        check("rst_rd", {rd_rdy_o, rd_num_o, rd_bank_o, rd_data_o}, 0);
        check("rst_wr_rdy", wr_rdy_o, 1);
        rst = 1'b0;
        tick();

        // plain refill
        push_refill(32'h0000_1008);
        rd_addr_i = 32'h0000_1008;
        rd_req_i  = 1'b1;
        wait_refill(1'b1);

        // write-back
        base = wgrants;
        push_write(32'h0000_2000, 128'h44444444_33333333_22222222_11111111);
        wr_addr_i = 32'h0000_2000;
        wr_data_i = 128'h44444444_33333333_22222222_11111111;
        wr_req_i  = 1'b1;
        tick();
        wr_req_i  = 1'b0;
        wr_data_i = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
        check("wr_rdy_busy", wr_rdy_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (wr_rdy_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("wr_rdy_free", seen, 1);
        check("wr_beats", wgrants - base, 4);
        check("wr_rdy_lat", cyc - last_wg_cyc, 1);
        check("wr_drain", exp_mem.size(), 0);

        // simultaneous write-back and refill: all writes precede the first read
        base = wgrants;
        push_write(32'h0000_3000, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
        push_refill(32'h0000_4000);
        wr_addr_i = 32'h0000_3000;
        wr_data_i = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
        wr_req_i  = 1'b1;
        rd_addr_i = 32'h0000_4000;
        rd_req_i  = 1'b1;
        tick();
        wr_req_i  = 1'b0;
        wait_refill(1'b0);
        check("sim_wr_beats", wgrants - base, 4);

        // stalled grant on the first read request
        base      = n_stall;
        stall_cfg = 5;
        stall_id++;
        push_refill(32'h0000_5004);
        rd_addr_i = 32'h0000_5004;
        rd_req_i  = 1'b1;
        wait_refill(1'b1);
        check("stall_cycles", n_stall - base, 5);

        // spurious rvalid while idle
        dv = n_deliv;
        stray_id++;
        tick();
        tick();
        check("spur_req", mem_req_o, 0);
        check("spur_wr_rdy", wr_rdy_o, 1);
        check("spur_deliv", n_deliv - dv, 0);

        // reset after the second refill beat
        dv = n_deliv;
        push_refill(32'h0000_6000);
        rd_addr_i = 32'h0000_6000;
        rd_req_i  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (n_deliv - dv == 2) break;
        end
        check("rst_mid_beats", n_deliv - dv, 2);
        rst      = 1'b1;
        rd_req_i = 1'b0;
        tick();
        check("rst_mid_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 0);
        check("rst_mid_rd", {rd_rdy_o, rd_num_o, rd_bank_o, rd_data_o}, 0);
        check("rst_mid_wr_rdy", wr_rdy_o, 1);
        rst = 1'b0;
        stray_id++;
        tick();
        tick();
        tick();
        check("rst_no_resume", n_deliv - dv, 2);
        check("rst_idle_req", mem_req_o, 0);

        // refill still works after the reset
        push_refill(32'h0000_1004);
        rd_addr_i = 32'h0000_1004;
        rd_req_i  = 1'b1;
        wait_refill(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
